imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the instruction memory size in 32-bit words.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: a level sampled each cycle; a high value requests a load.
REQ-005 Port word_count, input, 7 bits: the number of words to load; it SHALL be sampled only in the cycle where start is accepted.
REQ-006 Port byte_valid, input, 1 bit: the upstream byte source has a byte available.
REQ-007 Port byte_data, input, 8 bits: the byte payload.
REQ-008 Port byte_ready, output, 1 bit: the block can accept a byte.
REQ-009 Port mem_we, output, 1 bit: the instruction memory write strobe.
REQ-010 Port mem_addr, output, 6 bits: the instruction memory word address.
REQ-011 Port mem_wdata, output, 32 bits: the instruction word being written.
REQ-012 Port core_reset, output, 1 bit, active-high: holds the processor core in reset.
REQ-013 Port busy, output, 1 bit: high while in RECV or WRITE.
REQ-014 Port done, output, 1 bit: high while in DONE.
REQ-015 Port error, output, 1 bit: high while in ERR.

Function
REQ-016 The FSM SHALL have the states IDLE, RECV, WRITE, DONE and ERR.
REQ-017 In IDLE, DONE or ERR, start=1 SHALL do the following:
- word_count of 0, or above DEPTH: go to ERR.
- otherwise: latch the count, clear the word index and byte index, and go to RECV.
REQ-018 In RECV and WRITE, start SHALL be ignored.
REQ-019 byte_ready SHALL equal 1 only in RECV, driven from registered state.
- A byte is accepted only when byte_valid=1 and byte_ready=1.
- The block SHALL NOT accept a byte in any other cycle.
REQ-020 Bytes SHALL be assembled little-endian:
- byte index 0 goes to bits [7:0];
- byte index 1 goes to [15:8];
- byte index 2 goes to [23:16];
- byte index 3 goes to [31:24].
REQ-021 Acceptance of byte index 3 SHALL move the FSM to WRITE on the next edge.
REQ-022 In WRITE, for exactly one cycle:
- mem_we SHALL be 1;
- mem_addr SHALL equal the word index;
- mem_wdata SHALL equal the assembled word.
REQ-023 Leaving WRITE:
- if the word index equals count-1, go to DONE;
- otherwise increment the word index, clear the byte index, and go to RECV.
REQ-024 In all cycles other than WRITE, mem_we SHALL be 0.
REQ-025 Throughput with byte_valid held high SHALL be 5 cycles per word (4 accepts plus 1 write).
REQ-026 DONE SHALL be entered on the edge after the final write.
REQ-027 core_reset SHALL be 1 in every state except DONE, and 0 in DONE.
REQ-028 core_reset SHALL be driven from a register (glitch-free).
REQ-029 A stall (byte_valid=0) in RECV SHALL hold all state indefinitely; there is no timeout.
REQ-030 A start in DONE with a valid count SHALL restart the load, re-asserting core_reset on the next edge.
REQ-031 A start in ERR with a valid count SHALL enter RECV and clear error.
REQ-032 word_count equal to DEPTH SHALL be legal, and the final write SHALL be to mem_addr = DEPTH-1.

Reset
REQ-033 reset=0 SHALL immediately force the following, independent of clk:
- state = IDLE;
- byte_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
- core_reset = 1;
- busy = 0, done = 0, error = 0;
- all indices = 0.
REQ-034 A reset asserted mid-load SHALL discard any partial word and cause no memory write.
REQ-035 After a mid-load reset, the next load SHALL restart at address 0.
REQ-036 After reset deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-037 Single word: word_count=1, then bytes 0x13, 0x00, 0x50, 0x00 with byte_valid held high ->
- one mem_we pulse with addr 0 and data 0x00500013, in the 5th cycle after start is accepted;
- done=1 and core_reset=0 on the next edge.
REQ-038 Full memory: word_count=64 with the byte value equal to (word index × 4 + byte index) ->
- 64 writes at addr 0..63;
- word 63 data = 0xFFFEFDFC;
- no mem_we in the cycle after DONE is entered.
REQ-039 Backpressure: word_count=2 with byte_valid toggled 1,0,1,0 ->
- byte_ready stays high throughout RECV;
- only the valid bytes are accepted;
- data matches a non-stalled run.
REQ-040 Error and recovery:
- word_count=0 -> error=1, core_reset=1, byte_ready=0;
- word_count=65 -> error=1, same outputs;
- then start with word_count=1 -> error=0 and busy=1 on the next edge.
REQ-041 Reset mid-load: reset=0 after 2 bytes of word 0 ->
- all outputs take reset values asynchronously;
- no mem_we is seen;
- a following load writes addr 0 first.
REQ-042 Reload: start=1 in DONE with word_count=3 -> core_reset=1 on the next edge, then 3 writes, then done.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader holding the core in reset until the image is written
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  state_t      state;
  logic [6:0]  count;
  logic [5:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] partial;

  // Load sequencer: every output is a register updated together with the state,
  // so byte_ready/core_reset/status never glitch and always match the state entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 7'd0;
      word_idx   <= 6'd0;
      byte_idx   <= 2'd0;
      partial    <= 24'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 6'd0;
      mem_wdata  <= 32'd0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse; only the RECV->WRITE transition raises it.
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            core_reset <= 1'b1;
            done       <= 1'b0;
            if (word_count == 7'd0 || word_count > DEPTH_W) begin
              state      <= ERR;
              error      <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end else begin
              state      <= RECV;
              count      <= word_count;
              word_idx   <= 6'd0;
              byte_idx   <= 2'd0;
              error      <= 1'b0;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        RECV: begin
          // byte_ready is high throughout RECV, so byte_valid alone qualifies acceptance here.
          if (byte_valid && byte_ready) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: partial[7:0]   <= byte_data;
              2'd1: partial[15:8]  <= byte_data;
              2'd2: partial[23:16] <= byte_data;
              default: begin
                mem_wdata  <= {byte_data, partial};
                mem_addr   <= word_idx;
                mem_we     <= 1'b1;
                byte_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if ({1'b0, word_idx} == count - 7'd1) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            word_idx   <= word_idx + 6'd1;
            byte_idx   <= 2'd0;
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          error      <= 1'b0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int we_total = 0;
  int last_we_cyc = -1;
  logic [5:0]  last_we_addr = 6'd0;
  logic [31:0] last_we_data = 32'd0;

  int          exp_addr[$];
  logic [31:0] exp_data[$];

  imem_loader #(.DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte stream for word w, byte b of a given image pattern.
  function automatic logic [7:0] byte_of(input int pat, input int w, input int b);
    logic [7:0] fixed [4];
    fixed[0] = 8'h13; fixed[1] = 8'h00; fixed[2] = 8'h50; fixed[3] = 8'h00;
    case (pat)
      0:       return fixed[b];
      1:       return 8'(w * 4 + b);
      2:       return 8'(w * 29 + b * 7 + 3);
      3:       return 8'(160 + w * 16 + b);
      default: return 8'(90 ^ (w * 4 + b));
    endcase
  endfunction

  // Output checker: structural invariants every cycle plus the write scoreboard.
  always @(negedge clk) begin
    check1("inv_core_reset_vs_done", core_reset, !done);
    check1("inv_status_onehot", ($countones({busy, done, error}) <= 1), 1'b1);
    check1("inv_ready_implies_busy", (!byte_ready || busy), 1'b1);
    check1("inv_we_only_in_write", (!mem_we || (busy && !byte_ready)), 1'b1);
    if (mem_we) begin
      we_total++;
      last_we_cyc  = cyc_n;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
      end else begin
        check32("write_addr", 32'(mem_addr), exp_addr.pop_front());
        check32("write_data", mem_wdata, exp_data.pop_front());
      end
    end
  end

  // Runs one load starting at a negedge; returns at the negedge where DONE is first seen.
  task automatic run_load(input int n, input int pat, input bit stall);
    int idx;
    int budget;
    int start_cyc;
    int done_cyc;
    bit toggle;
    bit prev_stall;
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(w);
      exp_data.push_back({byte_of(pat, w, 3), byte_of(pat, w, 2), byte_of(pat, w, 1), byte_of(pat, w, 0)});
    end
    start = 1'b1;
    word_count = 7'(n);
    @(negedge clk);
    start = 1'b0;
    word_count = 7'h55;
    start_cyc = cyc_n;
    check1("start_busy", busy, 1'b1);
    check1("start_ready", byte_ready, 1'b1);
    check1("start_core_reset", core_reset, 1'b1);
    check1("start_error_clear", error, 1'b0);
    check1("start_done_clear", done, 1'b0);
    idx = 0; budget = 0; toggle = 1'b0; prev_stall = 1'b0;
    while (idx < 4 * n && budget < 2000) begin
      if (prev_stall) check1("stall_ready_held", byte_ready, 1'b1);
      prev_stall = 1'b0;
      if (byte_ready) begin
        if (stall && toggle) begin
          byte_valid = 1'b0;
          toggle = 1'b0;
          prev_stall = 1'b1;
        end else begin
          byte_valid = 1'b1;
          byte_data = byte_of(pat, idx / 4, idx % 4);
          idx++;
          toggle = 1'b1;
        end
      end else begin
        byte_valid = 1'b1;
        byte_data = 8'hEE;
      end
      @(negedge clk);
      budget++;
    end
    byte_valid = 1'b1;
    byte_data = 8'hEE;
    budget = 0;
    while (!done && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check1("done_reached", done, 1'b1);
    done_cyc = cyc_n;
    check1("done_core_released", core_reset, 1'b0);
    check1("done_busy_clear", busy, 1'b0);
    check1("done_no_we", mem_we, 1'b0);
    check32("last_write_before_done", 32'(last_we_cyc), 32'(done_cyc - 1));
    if (!stall) check32("load_cycles", 32'(done_cyc - start_cyc), 32'(5 * n));
    check32("pending_writes", 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    int we_before;
    reset = 1'b1;
    start = 1'b0;
    word_count = 7'd0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    #1 reset = 1'b0;
    #1;
    check1("rst_ready", byte_ready, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check32("rst_addr", 32'(mem_addr), 32'd0);
    check32("rst_wdata", mem_wdata, 32'd0);
    check1("rst_core_reset", core_reset, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check1("idle_hold_busy", busy, 1'b0);
    check1("idle_hold_core_reset", core_reset, 1'b1);

    // Single word
    run_load(1, 0, 1'b0);
    check32("single_addr_literal", 32'(last_we_addr), 32'd0);
    check32("single_data_literal", last_we_data, 32'h00500013);

    // Error and recovery
    start = 1'b1; word_count = 7'd0;
    @(negedge clk);
    start = 1'b0;
    check1("err0_error", error, 1'b1);
    check1("err0_core_reset", core_reset, 1'b1);
    check1("err0_ready", byte_ready, 1'b0);
    check1("err0_done", done, 1'b0);
    start = 1'b1; word_count = 7'd65;
    @(negedge clk);
    start = 1'b0;
    check1("err65_error", error, 1'b1);
    check1("err65_core_reset", core_reset, 1'b1);
    check1("err65_ready", byte_ready, 1'b0);
    @(negedge clk);
    check1("err_hold", error, 1'b1);
    run_load(1, 2, 1'b0);

    // Full memory
    we_before = we_total;
    run_load(64, 1, 1'b0);
    check32("full_write_count", 32'(we_total - we_before), 32'd64);
    check32("full_last_addr_literal", 32'(last_we_addr), 32'd63);
    check32("full_last_data_literal", last_we_data, 32'hFFFEFDFC);
    @(negedge clk);
    check1("full_after_done_no_we", mem_we, 1'b0);
    check1("full_done_held", done, 1'b1);

    // Reload from DONE
    we_before = we_total;
    run_load(3, 2, 1'b0);
    check32("reload_write_count", 32'(we_total - we_before), 32'd3);

    // Backpressure versus unstalled run of the same image
    run_load(2, 3, 1'b0);
    run_load(2, 3, 1'b1);
    check32("stall_last_data_literal", last_we_data, 32'hB3B2B1B0);

    // Reset mid-load after two bytes of word 0
    start = 1'b1; word_count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      byte_valid = 1'b1;
      byte_data = byte_of(4, 0, b);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    we_before = we_total;
    #2 reset = 1'b0;
    #1;
    check1("midrst_ready", byte_ready, 1'b0);
    check1("midrst_we", mem_we, 1'b0);
    check32("midrst_addr", 32'(mem_addr), 32'd0);
    check32("midrst_wdata", mem_wdata, 32'd0);
    check1("midrst_core_reset", core_reset, 1'b1);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_error", error, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'hEE;
    repeat (3) @(negedge clk);
    check1("midrst_idle_busy", busy, 1'b0);
    check32("midrst_no_write", 32'(we_total - we_before), 32'd0);
    run_load(2, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
